// File: rtl/mby_egr_pkg.sv
// Shared egress types and widths for the MIM write path.
// Request bundle, receiver FSM states and default FIFO depth.
package mby_egr_pkg;

   localparam int W_SEG_PTR        = 20;
   localparam int W_SEMA           = 2;
   localparam int W_WD_SEL         = 3;
   localparam int W_REQ_ID         = 13;
   localparam int W_WORD_BITS      = 64;
   localparam int W_XACT_CREDITS   = 8;
   localparam int MIM_WR_RCV_DEPTH = 8;

   typedef struct packed {
      logic [W_SEG_PTR-1:0]   seg_ptr;
      logic [W_SEMA-1:0]      sema;
      logic [W_WD_SEL-1:0]    wd_sel;
      logic [W_REQ_ID-1:0]    id;
      logic [W_WORD_BITS-1:0] data;
   } mim_wr_req_t;

   typedef enum logic {
      RCV_INIT,
      RCV_RUN
   } mim_wr_rcv_state_t;

endpackage

// File: rtl/mim_wr_if.sv
// MIM write request channel, egress initiator to MIM responder.
// send: initiator side; receive: responder side (returns credits).
interface mim_wr_if;
   import mby_egr_pkg::*;

   logic                      valid;
   logic [W_SEG_PTR-1:0]      seg_ptr;
   logic [W_SEMA-1:0]         sema;
   logic [W_WD_SEL-1:0]       wd_sel;
   logic [W_REQ_ID-1:0]       id;
   logic [W_WORD_BITS-1:0]    data;
   logic [W_XACT_CREDITS-1:0] mim_wreq_credits;

   modport send (
      output valid, seg_ptr, sema, wd_sel, id, data,
      input  mim_wreq_credits
   );

   modport receive (
      input  valid, seg_ptr, sema, wd_sel, id, data,
      output mim_wreq_credits
   );

endinterface

// File: rtl/mby_mim_wr_fifo.sv
// Generic DEPTH x W synchronous flop FIFO; head read from the array.
// Ports: cclk, rst_n, push, pop, din, dout, occ, full, empty.
module mby_mim_wr_fifo
   import mby_egr_pkg::*;
#(
   parameter int DEPTH = MIM_WR_RCV_DEPTH,
   parameter int W     = $bits(mim_wr_req_t)
) (
   input  logic                       cclk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic                       pop,
   input  logic [W-1:0]               din,
   output logic [W-1:0]               dout,
   output logic [$clog2(DEPTH+1)-1:0] occ,
   output logic                       full,
   output logic                       empty
);

   localparam int AW = $clog2(DEPTH);
   localparam int OW = $clog2(DEPTH+1);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (occ == OW'(DEPTH));
   assign empty   = (occ == '0);
   // A push into a full FIFO is dropped even if the head pops this cycle.
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   // Head reads as zero when empty so a reset clears the visible request.
   assign dout    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge cclk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase
      end
   end

   always_ff @(posedge cclk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/mby_mim_wr_rcv.sv
// MIM write responder: buffers requests, drains to MIM, returns credits.
// Ports: cclk, rst_n, wr_if(receive), mem_wr_*, fifo_occ, ovfl_err.
module mby_mim_wr_rcv
   import mby_egr_pkg::*;
#(
   parameter int DEPTH = MIM_WR_RCV_DEPTH
) (
   input  logic                       cclk,
   input  logic                       rst_n,
   mim_wr_if.receive                  wr_if,
   output logic                       mem_wr_valid,
   output mim_wr_req_t                mem_wr_req,
   input  logic                       mem_wr_ready,
   output logic [$clog2(DEPTH+1)-1:0] fifo_occ,
   output logic                       ovfl_err
);

   localparam int OW = $clog2(DEPTH+1);
   localparam int CW = W_XACT_CREDITS;
   localparam int RW = $bits(mim_wr_req_t);

   if (CW < OW) begin : g_cred_w_chk
      $error("W_XACT_CREDITS too narrow for DEPTH");
   end

   if (DEPTH < 2 || DEPTH > 64 || (DEPTH & (DEPTH-1)) != 0) begin : g_depth_chk
      $error("DEPTH must be a power of two in 2..64");
   end

   mim_wr_rcv_state_t state;
   logic [CW-1:0]     credits_q;
   logic [RW-1:0]     req_in;
   logic [RW-1:0]     fifo_dout;
   logic              full;
   logic              empty;
   logic              pop_fire;

   assign req_in = {wr_if.seg_ptr, wr_if.sema, wr_if.wd_sel,
                    wr_if.id, wr_if.data};

   mby_mim_wr_fifo #(
      .DEPTH (DEPTH),
      .W     (RW)
   ) u_fifo (
      .cclk  (cclk),
      .rst_n (rst_n),
      .push  (wr_if.valid),
      .pop   (mem_wr_ready),
      .din   (req_in),
      .dout  (fifo_dout),
      .occ   (fifo_occ),
      .full  (full),
      .empty (empty)
   );

   assign mem_wr_valid           = !empty;
   assign mem_wr_req             = fifo_dout;
   assign pop_fire               = mem_wr_valid && mem_wr_ready;
   assign wr_if.mim_wreq_credits = credits_q;

   // INIT grants the full depth once; RUN returns one credit per pop.
   always_ff @(posedge cclk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= RCV_INIT;
         credits_q <= '0;
         ovfl_err  <= 1'b0;
      end else begin
         unique case (state)
            RCV_INIT: begin
               credits_q <= CW'(DEPTH);
               state     <= RCV_RUN;
            end
            RCV_RUN: begin
               credits_q <= CW'(pop_fire);
            end
         endcase
         if (wr_if.valid && full) ovfl_err <= 1'b1;
      end
   end

   // Credits held here plus entries queued can never exceed the grant.
   a_credit_bal: assert property (@(posedge cclk) disable iff (!rst_n)
      (int'(fifo_occ) + int'(credits_q)) <= DEPTH);

   a_req_stable: assert property (@(posedge cclk) disable iff (!rst_n)
      (mem_wr_valid && !mem_wr_ready) |=> $stable(mem_wr_req));

   a_valid_known: assert property (@(posedge cclk)
      rst_n |-> !$isunknown(mem_wr_valid));

endmodule

// File: tb/tb_mby_mim_wr_rcv.sv
// Scoreboard bench for mby_mim_wr_rcv.
// Drives wr_if as initiator, models occupancy, credits and order.
module tb_mby_mim_wr_rcv;
   import mby_egr_pkg::*;

   localparam int DEPTH = 8;

   logic                         cclk;
   logic                         rst_n;
   logic                         mem_wr_valid;
   mim_wr_req_t                  mem_wr_req;
   logic                         mem_wr_ready;
   logic [$clog2(DEPTH+1)-1:0]   fifo_occ;
   logic                         ovfl_err;

   mim_wr_if wr_if ();

   mby_mim_wr_rcv #(.DEPTH(DEPTH)) dut (
      .cclk         (cclk),
      .rst_n        (rst_n),
      .wr_if        (wr_if),
      .mem_wr_valid (mem_wr_valid),
      .mem_wr_req   (mem_wr_req),
      .mem_wr_ready (mem_wr_ready),
      .fifo_occ     (fifo_occ),
      .ovfl_err     (ovfl_err)
   );

   initial cclk = 1'b0;
   always #5 cclk = ~cclk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag,
                      input logic [127:0] got,
                      input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
      end
   endtask

   // Reference model, evaluated mid-cycle between rising edges.
   mim_wr_req_t             sb_q[$];
   int                      m_occ  = 0;
   bit                      m_init = 1'b1;
   bit                      m_ovfl = 1'b0;
   logic [W_XACT_CREDITS-1:0] m_cred = '0;
   bit                      m_pop;
   mim_wr_req_t             m_req;

   always @(negedge cclk) begin
      if (!rst_n) begin
         chk("rst_valid", mem_wr_valid, 0);
         chk("rst_occ", fifo_occ, 0);
         chk("rst_req", mem_wr_req, 0);
         chk("rst_cred", wr_if.mim_wreq_credits, 0);
         chk("rst_ovfl", ovfl_err, 0);
         sb_q.delete();
         m_occ  = 0;
         m_init = 1'b1;
         m_ovfl = 1'b0;
         m_cred = '0;
      end else begin
         chk("occ", fifo_occ, m_occ);
         chk("valid", mem_wr_valid, m_occ != 0);
         chk("credits", wr_if.mim_wreq_credits, m_cred);
         chk("ovfl", ovfl_err, m_ovfl);
         if (m_occ != 0) chk("head", mem_wr_req, sb_q[0]);
         m_pop = (m_occ != 0) && mem_wr_ready;
         if (m_pop) void'(sb_q.pop_front());
         m_cred = m_init ? W_XACT_CREDITS'(DEPTH)
                         : W_XACT_CREDITS'(m_pop);
         m_init = 1'b0;
         if (wr_if.valid) begin
            if (m_occ == DEPTH) begin
               m_ovfl = 1'b1;
            end else begin
               m_req.seg_ptr = wr_if.seg_ptr;
               m_req.sema    = wr_if.sema;
               m_req.wd_sel  = wr_if.wd_sel;
               m_req.id      = wr_if.id;
               m_req.data    = wr_if.data;
               sb_q.push_back(m_req);
               m_occ++;
            end
         end
         if (m_pop) m_occ--;
      end
   end

   task automatic cyc();
      @(posedge cclk);
      #1;
   endtask

   task automatic set_req(input logic [12:0] id,
                          input logic [19:0] seg,
                          input logic [2:0]  wd);
      wr_if.valid   = 1'b1;
      wr_if.id      = id;
      wr_if.seg_ptr = seg;
      wr_if.wd_sel  = wd;
      wr_if.sema    = id[1:0];
      wr_if.data    = {$urandom(), $urandom()};
   endtask

   initial begin
      rst_n         = 1'b0;
      mem_wr_ready  = 1'b0;
      wr_if.valid   = 1'b0;
      wr_if.id      = '0;
      wr_if.seg_ptr = '0;
      wr_if.wd_sel  = '0;
      wr_if.sema    = '0;
      wr_if.data    = '0;
      repeat (3) cyc();
      rst_n = 1'b1;

      // Idle after reset: one-cycle grant of DEPTH
      repeat (4) cyc();

      // Single write, ready high
      mem_wr_ready = 1'b1;
      set_req(13'h1A, 20'h12345, 3'd3);
      cyc();
      wr_if.valid = 1'b0;
      chk("single_valid", mem_wr_valid, 1);
      chk("single_seg", mem_wr_req.seg_ptr, 20'h12345);
      chk("single_id", mem_wr_req.id, 13'h1A);
      chk("single_wd", mem_wr_req.wd_sel, 3);
      repeat (3) cyc();

      // Backpressure: fill to DEPTH
      mem_wr_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         set_req(13'(12'h100 + i), 20'(i * 3), 3'(i));
         cyc();
      end
      wr_if.valid = 1'b0;
      cyc();
      chk("bp_full", fifo_occ, DEPTH);
      chk("bp_nocred", wr_if.mim_wreq_credits, 0);

      // Overflow while full, then with a same-cycle pop
      set_req(13'h1FF, 20'hFFFFF, 3'd7);
      cyc();
      chk("ovfl_set", ovfl_err, 1);
      chk("ovfl_occ", fifo_occ, DEPTH);
      set_req(13'h1FE, 20'hEEEEE, 3'd6);
      mem_wr_ready = 1'b1;
      cyc();
      wr_if.valid = 1'b0;
      chk("ovfl_pop_occ", fifo_occ, DEPTH - 1);
      repeat (DEPTH + 2) cyc();
      chk("drain_occ", fifo_occ, 0);
      chk("ovfl_sticky", ovfl_err, 1);

      // Streaming at occupancy 4 across pointer wrap
      mem_wr_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         set_req(13'(12'h200 + i), 20'(12'hA00 + i), 3'(i));
         cyc();
      end
      mem_wr_ready = 1'b1;
      for (int i = 0; i < 32; i++) begin
         set_req(13'(12'h204 + i), 20'(12'hB00 + i), 3'(i));
         cyc();
         chk("stream_occ", fifo_occ, 4);
      end
      wr_if.valid = 1'b0;
      repeat (6) cyc();

      // Reset with entries queued
      mem_wr_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         set_req(13'(12'h300 + i), 20'(12'hC00 + i), 3'(i));
         cyc();
      end
      wr_if.valid = 1'b0;
      chk("pre_rst_occ", fifo_occ, 5);
      rst_n = 1'b0;
      #1;
      chk("arst_valid", mem_wr_valid, 0);
      chk("arst_occ", fifo_occ, 0);
      chk("arst_ovfl", ovfl_err, 0);
      chk("arst_req", mem_wr_req, 0);
      repeat (2) cyc();
      rst_n = 1'b1;
      mem_wr_ready = 1'b1;
      repeat (3) cyc();
      for (int i = 0; i < 3; i++) begin
         set_req(13'(12'h400 + i), 20'(12'hD00 + i), 3'(i));
         cyc();
      end
      wr_if.valid = 1'b0;
      repeat (5) cyc();
      chk("sb_empty", sb_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
